mresc_wrapper_sobel3x3_x_8b_g2: RTL and testbench
=================================================

MRESC_WRAPPER_SOBEL3X3_X_8B_G2 -- requirements
Module: mresc_wrapper_sobel3x3_x_8b_g2

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Parameter SEED_R, default 8'h01: reset/reload seed of the value LFSR.
REQ-003 Parameter SEED_S, default 8'hA5: reset/reload seed of the select LFSR.
REQ-004 clk  input  1: rising-edge clock.
REQ-005 reset  input  1: asynchronous active-low reset.
REQ-006 x_1_bin, x_2_bin, x_3_bin  input  8 each: left, centre and right pixels of the row above, unsigned.
REQ-007 x_4_bin, x_5_bin, x_6_bin  input  8 each: left, centre and right pixels of the row below, unsigned.
REQ-008 start  input  1: high = idle/clear, low = run.
REQ-009 done  output  1: high when z_bin holds a completed result.
REQ-010 z_bin  output  8: edge magnitude, unsigned.

Function
REQ-011 Target function SHALL be z ≈ 256·|(x4+2·x5+x6) − (x1+2·x2+x3)| / 1024, saturated to 255 (scaled vertical Sobel magnitude).
REQ-012 Value LFSR R SHALL be 8-bit maximal-length Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advancing once per run cycle.
REQ-013 Select LFSR S SHALL use the same polynomial, seeded SEED_S, advancing once per run cycle; sel = S[1:0].
REQ-014 Per run cycle, column selection SHALL be: sel 00 → column 1, sel 01 or 10 → column 2, sel 11 → column 3 (1:2:1 weights).
REQ-015 Stream bits SHALL be a = (selected above-row pixel > R) and b = (selected below-row pixel > R), using the same R and sel for both rows (correlated streams).
REQ-016 Output bit SHALL be a XOR b, equal to |a−b| for correlated streams.
REQ-017 While start=1, the block SHALL synchronously reload R=SEED_R and S=SEED_S, clear the cycle counter and ones counter, and drive done=0; z_bin SHALL hold its last value.
REQ-018 While start=0 and done=0, each clock SHALL add the output bit to a 9-bit ones counter and increment the 8-bit cycle counter.
REQ-019 After exactly 256 run cycles, z_bin SHALL be loaded with min(ones, 255) and done SHALL be set on the same edge, 256 clocks after the first clock edge with start=0.
REQ-020 While done=1 and start=0, all state SHALL freeze and done SHALL stay high.
REQ-021 Raising start at any time, including mid-run, SHALL abort the run per REQ-017.
REQ-022 Inputs SHALL be sampled every run cycle and SHALL be held stable by the user for the whole run.

Reset
REQ-023 On reset=0, asynchronously: z_bin=0, done=0, counters=0, R=SEED_R, S=SEED_S.
REQ-024 After reset is released, the block SHALL be idle until start=0 is seen.

Structure
REQ-025 A shared package SHALL hold the width (8), run length (256), LFSR polynomial taps and default seeds.
REQ-026 The design SHALL use one sub-module, sc_lfsr8 (seedable, with a load input), instantiated twice; comparators, mux, XOR and counters SHALL be inline.

Verification
REQ-027 All inputs 0, start high→low → done after 256 clocks, z_bin=0.
REQ-028 Above row = below row = 8'd137 → z_bin=0 exactly (correlation check).
REQ-029 Above row 0, below row 255 → z_bin within 250..255; repeat with rows swapped for the same result.
REQ-030 Above row 100, below row 200 → z_bin within 92..108.
REQ-031 start raised at run cycle 100, then lowered → done stays low until 256 clocks after relaunch, and the result equals an uninterrupted run.
REQ-032 reset asserted mid-run → done=0 and z_bin=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mresc_wrapper_sobel3x3_x_8b_g2_pkg.sv
// Shared widths, run length, LFSR polynomial and default seeds for the
// stochastic vertical-Sobel magnitude block.
package mresc_wrapper_sobel3x3_x_8b_g2_pkg;

   localparam int unsigned W       = 8;
   localparam int unsigned RUN_LEN = 256;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned ONES_W  = 9;

   // x^8 + x^6 + x^5 + x^4 + 1, feedback taken from bits 7,5,4,3 of a left shifter
   localparam logic [W-1:0] LFSR_TAPS  = 8'hB8;
   localparam logic [W-1:0] SEED_R_DEF = 8'h01;
   localparam logic [W-1:0] SEED_S_DEF = 8'hA5;

   typedef enum logic [1:0] {
      SEL_C1  = 2'b00,
      SEL_C2A = 2'b01,
      SEL_C2B = 2'b10,
      SEL_C3  = 2'b11
   } sel_e;

   typedef struct packed {
      logic [W-1:0] left;
      logic [W-1:0] centre;
      logic [W-1:0] right;
   } row_t;

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] q);
      return {q[W-2:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mresc_wrapper_sobel3x3_x_8b_g2_sc_lfsr8.sv
// Seedable 8-bit Fibonacci LFSR with synchronous reload and step enable.
module sc_lfsr8
   import mresc_wrapper_sobel3x3_x_8b_g2_pkg::*;
#(
   parameter logic [W-1:0] SEED = SEED_R_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         en_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] lfsr_q;
   logic [W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (en_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q_o = lfsr_q;

endmodule

// File: rtl/mresc_wrapper_sobel3x3_x_8b_g2.sv
// Stochastic-computing vertical Sobel magnitude: correlated unipolar streams,
// XOR subtraction, 256-cycle ones count saturated to 8 bits.
module mresc_wrapper_sobel3x3_x_8b_g2
   import mresc_wrapper_sobel3x3_x_8b_g2_pkg::*;
#(
   parameter logic [W-1:0] SEED_R = SEED_R_DEF,
   parameter logic [W-1:0] SEED_S = SEED_S_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] x_1_bin,
   input  logic [W-1:0] x_2_bin,
   input  logic [W-1:0] x_3_bin,
   input  logic [W-1:0] x_4_bin,
   input  logic [W-1:0] x_5_bin,
   input  logic [W-1:0] x_6_bin,
   input  logic         start,
   output logic         done,
   output logic [W-1:0] z_bin
);

   row_t              above_row_c;
   row_t              below_row_c;
   logic [W-1:0]      r_q;
   logic [W-1:0]      s_q;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [W-1:0]      z_q,    z_d;
   logic              done_q, done_d;
   logic              run_c;
   sel_e              sel_c;
   logic [W-1:0]      above_px_c;
   logic [W-1:0]      below_px_c;
   logic              bit_c;
   logic [ONES_W-1:0] ones_sum_c;

   assign above_row_c = '{left: x_1_bin, centre: x_2_bin, right: x_3_bin};
   assign below_row_c = '{left: x_4_bin, centre: x_5_bin, right: x_6_bin};
   assign run_c       = !start && !done_q;

   sc_lfsr8 #(.SEED(SEED_R)) u_lfsr_r (
      .clk    (clk),
      .rst_n  (reset),
      .load_i (start),
      .en_i   (run_c),
      .q_o    (r_q)
   );

   sc_lfsr8 #(.SEED(SEED_S)) u_lfsr_s (
      .clk    (clk),
      .rst_n  (reset),
      .load_i (start),
      .en_i   (run_c),
      .q_o    (s_q)
   );

   // 1:2:1 column pick shared by both rows so the two streams stay correlated
   always_comb begin
      sel_c = sel_e'(s_q[1:0]);
      case (sel_c)
         SEL_C1: begin
            above_px_c = above_row_c.left;
            below_px_c = below_row_c.left;
         end
         SEL_C2A, SEL_C2B: begin
            above_px_c = above_row_c.centre;
            below_px_c = below_row_c.centre;
         end
         default: begin
            above_px_c = above_row_c.right;
            below_px_c = below_row_c.right;
         end
      endcase
      bit_c = (above_px_c > r_q) ^ (below_px_c > r_q);
   end

   always_comb begin
      cnt_d      = cnt_q;
      ones_d     = ones_q;
      z_d        = z_q;
      done_d     = done_q;
      ones_sum_c = ones_q + ONES_W'(bit_c);
      if (start) begin
         cnt_d  = '0;
         ones_d = '0;
         done_d = 1'b0;
      end else if (!done_q) begin
         cnt_d  = cnt_q + CNT_W'(1);
         ones_d = ones_sum_c;
         if (cnt_q == CNT_W'(RUN_LEN - 1)) begin
            done_d = 1'b1;
            z_d    = (ones_sum_c > ONES_W'(255)) ? W'(255) : ones_sum_c[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         ones_q <= '0;
         z_q    <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ones_q <= ones_d;
         z_q    <= z_d;
         done_q <= done_d;
      end
   end

   assign done  = done_q;
   assign z_bin = z_q;

endmodule

// File: tb/tb_mresc_wrapper_sobel3x3_x_8b_g2.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor
// compares them whenever done rises.
module tb_mresc_wrapper_sobel3x3_x_8b_g2;

   typedef struct {
      int unsigned exp;
      int unsigned lo;
      int unsigned hi;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] x1, x2, x3, x4, x5, x6;
   logic       start;
   logic       done;
   logic [7:0] z;

   int   checks;
   int   errors;
   exp_t sb_q[$];
   logic done_prev;

   mresc_wrapper_sobel3x3_x_8b_g2 dut (
      .clk     (clk),
      .reset   (reset),
      .x_1_bin (x1),
      .x_2_bin (x2),
      .x_3_bin (x3),
      .x_4_bin (x4),
      .x_5_bin (x5),
      .x_6_bin (x6),
      .start   (start),
      .done    (done),
      .z_bin   (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] step8(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Reference: same stream construction computed directly in the bench
   function automatic int unsigned model_z(input logic [7:0] a1, input logic [7:0] a2,
                                           input logic [7:0] a3, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0]  r;
      logic [7:0]  s;
      logic [7:0]  pa;
      logic [7:0]  pb;
      int unsigned ones;
      r    = 8'h01;
      s    = 8'hA5;
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         case (s[1:0])
            2'b00:   begin pa = a1; pb = b1; end
            2'b11:   begin pa = a3; pb = b3; end
            default: begin pa = a2; pb = b2; end
         endcase
         if ((pa > r) != (pb > r)) ones++;
         r = step8(r);
         s = step8(s);
      end
      return (ones > 255) ? 255 : ones;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: compare on each rising edge of done
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_done: got z=%0d expected no result", z);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_z_exact", z, e.exp);
            checks++;
            if (z < e.lo || z > e.hi) begin
               errors++;
               $display("FAIL sb_z_range: got %0d expected %0d..%0d", z, e.lo, e.hi);
            end
         end
      end
      done_prev = done;
   end

   task automatic run_vec(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                          input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                          input int unsigned lo, input int unsigned hi, input int abort_at);
      exp_t e;
      int   n;
      @(negedge clk);
      x1 = a1; x2 = a2; x3 = a3; x4 = b1; x5 = b2; x6 = b3;
      start = 1'b1;
      @(negedge clk);
      e.exp = model_z(a1, a2, a3, b1, b2, b3);
      e.lo  = lo;
      e.hi  = hi;
      sb_q.push_back(e);
      start = 1'b0;
      if (abort_at > 0) begin
         repeat (abort_at) @(negedge clk);
         check("abort_done_low", done, 0);
         start = 1'b1;
         repeat (2) @(negedge clk);
         check("abort_idle_done", done, 0);
         start = 1'b0;
      end
      n = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (done) begin
            n = k;
            break;
         end
      end
      if (n == 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done after 256 clocks");
      end else begin
         check("done_latency", n, 256);
      end
      repeat (5) @(negedge clk);
      check("freeze_done", done, 1);
      check("freeze_z", z, e.exp);
      start = 1'b1;
      @(negedge clk);
      check("idle_done_clr", done, 0);
      check("idle_z_hold", z, e.exp);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      done_prev = 1'b0;
      reset     = 1'b0;
      start     = 1'b1;
      {x1, x2, x3, x4, x5, x6} = '0;
      repeat (2) @(negedge clk);
      check("reset_done", done, 0);
      check("reset_z", z, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", done, 0);

      run_vec(8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   0,   0,   0);
      run_vec(8'd137, 8'd137, 8'd137, 8'd137, 8'd137, 8'd137, 0,   0,   0);
      run_vec(8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255, 250, 255, 0);
      run_vec(8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   8'd0,   250, 255, 0);
      run_vec(8'd100, 8'd100, 8'd100, 8'd200, 8'd200, 8'd200, 92,  108, 0);
      run_vec(8'd10,  8'd60,  8'd200, 8'd220, 8'd30,  8'd90,  0,   255, 0);
      run_vec(8'd10,  8'd60,  8'd200, 8'd220, 8'd30,  8'd90,  0,   255, 100);
      run_vec(8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255, 250, 255, 0);

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_done", done, 0);
      check("async_rst_z", z, 0);
      @(negedge clk);
      start = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", done, 0);

      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
